// File: rtl/mctrl_pkg.sv
// rtl/mctrl_pkg.sv - shared states, opcodes and select encodings for multicycle_ctrl
package mctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWRITE,
      S_MEMWB,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BEQ,
      S_JAL,
      S_HALT
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RISC-V main control FSM (optional MCTRL_INSTRET_EN retire counter)
module multicycle_ctrl
   import mctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  op,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_write,
   output logic        adr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  result_src,
   output logic [1:0]  aluop,
`ifdef MCTRL_INSTRET_EN
   output logic [31:0] instret,
`endif
   output logic        illegal
);

   state_t state_q, state_d;

   // State register; reset always restarts at instruction fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and Moore outputs; only FETCH looks at mem_ready for its enables
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RD2;
      result_src = RES_ALUOUT;
      aluop      = ALUOP_ADD;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               default:           state_d = S_HALT;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            result_src = RES_DATA;
            state_d    = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_RD2;
            aluop     = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            aluop     = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_RD2;
            aluop     = ALUOP_SUB;
            pc_write  = zero;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
         S_HALT: begin
            illegal = 1'b1;
         end
         default: begin
            state_d = S_HALT;
         end
      endcase
   end

`ifdef MCTRL_INSTRET_EN
   logic [31:0] instret_q, instret_d;
   logic        retire;

   // An instruction retires when one of its final states hands back to FETCH
   always_comb begin
      retire    = (state_d == S_FETCH) &&
                  ((state_q == S_MEMWRITE) || (state_q == S_MEMWB) ||
                   (state_q == S_ALUWB)    || (state_q == S_BEQ));
      instret_d = retire ? instret_q + 32'd1 : instret_q;
   end

   // Retired-instruction counter, wraps naturally at 32 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instret_q <= 32'd0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  op;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
   logic [1:0]  alu_src_a, alu_src_b, result_src, aluop;
`ifdef MCTRL_INSTRET_EN
   logic [31:0] instret;
`endif

   multicycle_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_write  (mem_write),
      .adr_src    (adr_src),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .aluop      (aluop),
`ifdef MCTRL_INSTRET_EN
      .instret    (instret),
`endif
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [6:0]  op;
      logic        z;
      logic        rdy;
      logic [14:0] exp;
      logic [31:0] exp_ir;
   } step_t;

   step_t       q[$];
   logic [31:0] model_cnt = 32'd0;
   int          errors = 0;
   int          checks = 0;
   int          rw_seen = 0;
   int          mw_seen = 0;

   localparam logic [6:0] K_LW  = 7'b0000011;
   localparam logic [6:0] K_SW  = 7'b0100011;
   localparam logic [6:0] K_R   = 7'b0110011;
   localparam logic [6:0] K_I   = 7'b0010011;
   localparam logic [6:0] K_BEQ = 7'b1100011;
   localparam logic [6:0] K_JAL = 7'b1101111;
   localparam logic [6:0] K_BAD = 7'b1110011;

   // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,src_a,src_b,res,aluop,illegal}
   function automatic logic [14:0] outv(input logic rq, input logic wr, input logic ad,
                                        input logic irw, input logic pcw, input logic rw,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] r, input logic [1:0] alu,
                                        input logic ill);
      return {rq, wr, ad, irw, pcw, rw, a, b, r, alu, ill};
   endfunction

   task automatic add(input logic rst, input logic [6:0] o, input logic z, input logic rdy,
                      input logic [14:0] e);
      step_t s;
      s.rst = rst; s.op = o; s.z = z; s.rdy = rdy; s.exp = e; s.exp_ir = model_cnt;
      q.push_back(s);
   endtask

   task automatic rst_cycles(input int n, input logic rdy);
      model_cnt = 32'd0;
      for (int i = 0; i < n; i++) add(1'b1, 7'd0, 1'b0, rdy, outv(1,0,0,rdy,rdy,0,2'd0,2'd2,2'd2,2'd0,0));
   endtask

   task automatic fetch(input logic [6:0] o, input int waits);
      for (int i = 0; i < waits; i++) add(1'b0, o, 1'b0, 1'b0, outv(1,0,0,0,0,0,2'd0,2'd2,2'd2,2'd0,0));
      add(1'b0, o, 1'b0, 1'b1, outv(1,0,0,1,1,0,2'd0,2'd2,2'd2,2'd0,0));
      add(1'b0, o, 1'b0, 1'b1, outv(0,0,0,0,0,0,2'd1,2'd1,2'd0,2'd0,0));
   endtask

   task automatic mem_access(input logic [6:0] o, input logic wr, input int waits);
      add(1'b0, o, 1'b0, 1'b1, outv(0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0,0));
      for (int i = 0; i < waits; i++) add(1'b0, o, 1'b0, 1'b0, outv(1,wr,1,0,0,0,2'd0,2'd0,2'd0,2'd0,0));
      add(1'b0, o, 1'b0, 1'b1, outv(1,wr,1,0,0,0,2'd0,2'd0,2'd0,2'd0,0));
   endtask

   // One whole instruction: fetch+decode, its body, then it counts as retired
   task automatic instr(input logic [6:0] o, input int fw, input int mw, input logic z);
      fetch(o, fw);
      case (o)
         K_LW: begin
            mem_access(o, 1'b0, mw);
            add(1'b0, o, 1'b0, 1'b1, outv(0,0,0,0,0,1,2'd0,2'd0,2'd1,2'd0,0));
         end
         K_SW: mem_access(o, 1'b1, mw);
         K_R, K_I: begin
            add(1'b0, o, 1'b0, 1'b1, outv(0,0,0,0,0,0,2'd2,(o == K_R) ? 2'd0 : 2'd1,2'd0,2'd2,0));
            add(1'b0, o, 1'b0, 1'b1, outv(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,0));
         end
         K_BEQ: add(1'b0, o, z, 1'b1, outv(0,0,0,0,z,0,2'd2,2'd0,2'd0,2'd1,0));
         default: begin
            add(1'b0, o, 1'b0, 1'b1, outv(0,0,0,0,1,0,2'd1,2'd2,2'd0,2'd0,0));
            add(1'b0, o, 1'b0, 1'b1, outv(0,0,0,0,0,1,2'd0,2'd0,2'd0,2'd0,0));
         end
      endcase
      model_cnt = model_cnt + 32'd1;
   endtask

   task automatic pin_len(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: model cycles %0d, required %0d", name, got, want);
      end
   endtask

   task automatic pin_val(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   initial begin
      int n0;
      logic [14:0] act;
      rst_n = 1'b0; op = 7'd0; zero = 1'b0; mem_ready = 1'b0;

      rst_cycles(2, 1'b0);
      instr(K_LW, 2, 0, 0);
      n0 = q.size(); instr(K_LW, 0, 2, 0); pin_len("lw_2wait_len", q.size() - n0, 7);
      n0 = q.size(); instr(K_SW, 0, 0, 0); pin_len("sw_len", q.size() - n0, 4);
      n0 = q.size(); instr(K_R, 0, 0, 0);  pin_len("rtype_len", q.size() - n0, 4);
      instr(K_I, 1, 0, 0);
      n0 = q.size(); instr(K_BEQ, 0, 0, 1); pin_len("beq_len", q.size() - n0, 3);
      instr(K_BEQ, 0, 0, 0);
      n0 = q.size(); instr(K_JAL, 0, 0, 0); pin_len("jal_len", q.size() - n0, 4);
      instr(K_SW, 0, 1, 0);
      // lw abandoned by reset while waiting in its read access
      fetch(K_LW, 0);
      add(1'b0, K_LW, 1'b0, 1'b1, outv(0,0,0,0,0,0,2'd2,2'd1,2'd0,2'd0,0));
      add(1'b0, K_LW, 1'b0, 1'b0, outv(1,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,0));
      rst_cycles(2, 1'b1);
      instr(K_LW, 0, 0, 0);
      // unsupported opcode halts the core until reset
      fetch(K_BAD, 0);
      for (int i = 0; i < 6; i++) add(1'b0, K_BAD, i[0], i[1], outv(0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,1));
      rst_cycles(1, 1'b0);
      instr(K_R, 0, 0, 0);
      add(1'b0, 7'd0, 1'b0, 1'b0, outv(1,0,0,0,0,0,2'd0,2'd2,2'd2,2'd0,0));

      for (int c = 0; c < q.size(); c++) begin
         @(posedge clk); #1;
         rst_n = ~q[c].rst; op = q[c].op; zero = q[c].z; mem_ready = q[c].rdy;
         @(negedge clk);
         act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, aluop, illegal};
         checks++;
         if (act !== q[c].exp) begin
            errors++;
            $display("FAIL outputs cycle %0d: got %b, required %b", c, act, q[c].exp);
         end
         if (reg_write === 1'b1) rw_seen++;
         if (mem_write === 1'b1) mw_seen++;
`ifdef MCTRL_INSTRET_EN
         checks++;
         if (instret !== q[c].exp_ir) begin
            errors++;
            $display("FAIL instret cycle %0d: got %0d, required %0d", c, instret, q[c].exp_ir);
         end
`endif
      end

      pin_val("reg_write_cycles", rw_seen, 7);
      pin_val("mem_write_cycles", mw_seen, 3);
`ifdef MCTRL_INSTRET_EN
      pin_val("instret_final", int'(instret), 1);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle variant of the 32-bit RISC-V core. It sequences one shared ALU, one unified instruction/data memory port and the register file through fetch, decode, execute, memory and writeback steps. It drives `aluop` into the existing ALU decode block and stalls on a memory ready handshake. Supported instructions: lw, sw, R-type ALU, I-type ALU, beq and jal; any other opcode halts the core.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op`  in  7  opcode field of the instruction register.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access requested.
- `mem_write`  out  1  access is a write.
- `adr_src`  out  1  address select: 0 = PC, 1 = Result.
- `ir_write`  out  1  instruction register load enable.
- `pc_write`  out  1  PC load enable.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
- `alu_src_b`  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- `result_src`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `aluop`  out  2  00 = add, 01 = subtract, 10 = decode funct fields.
- `illegal`  out  1  sticky; set when the core is halted on an unsupported opcode.
- `instret`  out  32  retired-instruction count. Present only with `MCTRL_INSTRET_EN`.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB, EXECR, EXECI, ALUWB, BEQ, JAL, HALT.
- Outputs are Moore-style per state. Exception: `ir_write` and `pc_write` in FETCH are gated by `mem_ready`. All outputs not listed below are 0.
- FETCH:
  - `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `aluop`=00, `result_src`=10.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Go to DECODE on `mem_ready`, otherwise stay.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, `aluop`=00 (computes the branch target). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other → HALT
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, `aluop`=00. Go to MEMREAD if `op`=0000011, else MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1, `result_src`=00. Go to MEMWB on `mem_ready`.
- MEMWRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1, `result_src`=00. Go to FETCH on `mem_ready`.
- MEMWB: `reg_write`=1, `result_src`=01. Go to FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, `aluop`=10. Go to ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, `aluop`=10. Go to ALUWB.
- ALUWB: `reg_write`=1, `result_src`=00. Go to FETCH.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, `aluop`=01, `result_src`=00, `pc_write`=`zero`. Go to FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, `aluop`=00, `result_src`=00, `pc_write`=1. Go to ALUWB.
- HALT: `illegal`=1, all other outputs 0. Left only by reset.
- Memory handshake: while waiting, `mem_req`, `mem_write` and `adr_src` are held stable. The request drops in the cycle after `mem_ready`. `mem_write` is never 1 outside MEMWRITE.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` release) forces FETCH.
- Output values while in reset and at the first cycle after release: `mem_req`=1, `alu_src_b`=10, `result_src`=10; all others 0, with `ir_write`/`pc_write` following `mem_ready`; `illegal`=0; `instret`=0.
- Latency in cycles with zero-wait memory (`mem_ready`=1 throughout): lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Reset mid-instruction abandons it: no `reg_write` or `mem_write` completes after reset assertion.

## Configuration
- `MCTRL_INSTRET_EN` defined:
  - `instret` port present.
  - Increments by 1 on each transition into FETCH from MEMWRITE, MEMWB, ALUWB or BEQ.
  - 32-bit, wraps from 0xFFFFFFFF to 0. Never increments in HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `mctrl_pkg` holds:
  - the state enum;
  - the opcode constants (`OP_LOAD`, `OP_STORE`, `OP_RTYPE`, `OP_ITYPE`, `OP_BRANCH`, `OP_JAL`);
  - the encodings for `alu_src_a`, `alu_src_b`, `result_src` and `aluop`.
- Single module, no sub-module. The existing ALU decode block is instantiated alongside it in the control-unit top, fed by `aluop`.

## Test plan
- Reset with `mem_ready`=0 → FETCH outputs as listed; `ir_write`=0; stays in FETCH until `mem_ready`=1, then `ir_write`=`pc_write`=1 for one cycle.
- lw (`op`=0000011) with 2 wait cycles in MEMREAD → 7 cycles total; `reg_write`=1 only in MEMWB with `result_src`=01.
- sw (`op`=0100011), zero wait → `mem_write`=1 for exactly one cycle with `adr_src`=1; `reg_write` never asserted; back in FETCH after 4 cycles.
- beq with `zero`=1 → `pc_write`=1 in BEQ. Repeated with `zero`=0 → `pc_write`=0. Both take 3 cycles.
- jal → `pc_write`=1 in JAL, then `reg_write`=1 in ALUWB; 4 cycles.
- `op`=1110011 → HALT, `illegal`=1, `mem_req`=0 indefinitely; `rst_n` pulse clears it. With `MCTRL_INSTRET_EN`: `instret` equals the count of completed instructions and does not change in HALT.
